// File: rtl/rr_decode_pkg.sv
// rr_decode_pkg: shared types and helpers for the round-robin decode arbiter.
//   state_t  : arbiter FSM states {IDLE, GRANT, BUSY}
//   decode   : valid-gated one-hot decode (inactive bits 0, selected bit = value)
//   wrap_inc : x+1 modulo m, wrapping m-1 back to 0
package rr_decode_pkg;

  // Widest requester vector the helpers support; callers size-cast the result.
  localparam int unsigned MAX_M = 32;
  localparam int unsigned SELW  = $clog2(MAX_M);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BUSY
  } state_t;

  function automatic logic [MAX_M-1:0] decode(input logic [SELW-1:0] sel,
                                              input logic            valid,
                                              input logic            value);
    logic [MAX_M-1:0] oh;
    oh = '0;
    if (valid) oh[sel] = value;
    return oh;
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned x,
                                           input int unsigned m);
    return (x + 32'd1 >= m) ? 32'd0 : x + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker.
//   req   [M-1:0] : request vector
//   ptr   [N-1:0] : highest-priority index (always < M)
//   found         : at least one request is set
//   idx   [N-1:0] : first set request searching upward from ptr, wrapping M-1 -> 0
module rr_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned M = 4
) (
  input  logic [M-1:0] req,
  input  logic [N-1:0] ptr,
  output logic         found,
  output logic [N-1:0] idx
);

  logic [N:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < M; i++) begin
      // ptr < M and i < M, so one conditional subtract is a full modulo.
      cand = {1'b0, ptr} + (N+1)'(i);
      if (cand >= (N+1)'(M)) cand = cand - (N+1)'(M);
      if (!found && req[cand[N-1:0]]) begin
        found = 1'b1;
        idx   = cand[N-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: round-robin scheduler sharing one resource among M
// requesters, with a registered one-hot grant held through ack/done.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   req [M-1:0]: request levels
//   ack        : resource accepts the current grant (GRANT -> BUSY)
//   done       : resource finished (BUSY -> IDLE), single-cycle pulse
//   gnt [M-1:0]: registered one-hot grant, zero when idle
//   gnt_idx    : index of current or most recent grantee
//   busy       : resource owned (BUSY state)
//   tmo_err    : busy-timeout pulse
// Optional feature macro: RR_DECODE_ARBITER_TIMEOUT_EN enables the TMO-cycle
// busy timeout; without it tmo_err is tied low and BUSY waits for done.
module rr_decode_arbiter
  import rr_decode_pkg::*;
#(
  parameter int unsigned N   = 2,
  parameter int unsigned M   = 4,
  parameter int unsigned TMO = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  input  logic         ack,
  input  logic         done,
  output logic [M-1:0] gnt,
  output logic [N-1:0] gnt_idx,
  output logic         busy,
  output logic         tmo_err
);

  state_t       state_q, state_d;
  logic [N-1:0] sel_q, sel_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [M-1:0] gnt_q, gnt_d;
  logic         busy_q, busy_d;
  logic         pend_q, pend_d;
  logic         found;
  logic [N-1:0] pick_idx;
  logic [N-1:0] ptr_nxt;

`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = (TMO > 2) ? $clog2(TMO) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          tmo_hit;
  assign tmo_hit = (cnt_q == CW'(TMO - 1));
`endif

  rr_pick #(
    .N(N),
    .M(M)
  ) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (pick_idx)
  );

  assign ptr_nxt = N'(wrap_inc(32'(sel_q), M));

  // IDLE is split in two cycles by pend_q: the first registers the pick into
  // sel, the second registers the decoded grant from sel. This keeps the
  // decode off the picker path and guarantees a gap cycle between grants.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    pend_d  = 1'b0;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          gnt_d   = M'(decode(SELW'(sel_q), 1'b1, 1'b1));
          state_d = GRANT;
        end else if (found) begin
          sel_d  = pick_idx;
          pend_d = 1'b1;
        end
      end
      GRANT: begin
        if (ack) begin
          state_d = BUSY;
          busy_d  = 1'b1;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (!req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_nxt;
        end
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_nxt;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = sel_q;
  assign busy    = busy_q;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
  assign tmo_err = tmo_q;
`else
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter (N=2, M=4, TMO=8).
module tb_rr_decode_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       ack = 1'b0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       tmo_err;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_q[$];
  logic [3:0]  prev_gnt = '0;

  always #5 clk = ~clk;

  rr_decode_arbiter #(
    .N  (2),
    .M  (4),
    .TMO(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .ack    (ack),
    .done   (done),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .busy   (busy),
    .tmo_err(tmo_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue: push the expected grantee, then wait (bounded) for the grant.
  task automatic expect_grant(input int unsigned idx);
    int k;
    exp_q.push_back(idx);
    k = 0;
    while (gnt == 4'b0000 && k < 10) begin
      tick();
      k++;
    end
    if (gnt == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL grant_wait actual=none required=idx%0d", idx);
    end
  endtask

  task automatic finish_grant();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("busy_after_ack", busy, 1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("gnt_after_done", gnt, 0);
    chk("busy_after_done", busy, 0);
  endtask

  // Monitor: each new grant pops one expected grantee from the scoreboard.
  always @(negedge clk) begin
    int unsigned e;
    logic [3:0]  oh;
    if (!rst_n) begin
      prev_gnt = '0;
    end else begin
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", gnt, 0);
        end else begin
          e  = exp_q.pop_front();
          oh = 4'b0001 << e;
          chk("grant_onehot", gnt, oh);
          chk("grant_idx", gnt_idx, e);
        end
      end else if (gnt != 4'b0000 && gnt != prev_gnt) begin
        checks++;
        errors++;
        $display("FAIL grant_gap actual=%0h required=0 between grants", gnt);
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // 1: reset values with all requesting, then exact grant latency
    req = 4'b1111;
    tick(3);
    chk("rst_gnt", gnt, 0);
    chk("rst_idx", gnt_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo_err, 0);
    rst_n = 1'b1;
    exp_q.push_back(0);
    tick();
    chk("lat_edge1", gnt, 0);
    tick();
    chk("lat_edge2", gnt, 4'b0001);
    finish_grant();
    req = 4'b0000;
    chk("idx_kept", gnt_idx, 0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // 2: sparse requests from ptr=0, done outside BUSY ignored
    req = 4'b1010;
    expect_grant(1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_in_grant_gnt", gnt, 4'b0010);
    chk("done_in_grant_busy", busy, 0);
    finish_grant();
    expect_grant(3);
    finish_grant();
    req = 4'b0000;

    // 3: fairness with all requesting, ptr wraps 3 -> 0
    req = 4'b1111;
    expect_grant(0);
    finish_grant();
    expect_grant(1);
    finish_grant();
    expect_grant(2);
    finish_grant();
    expect_grant(3);
    finish_grant();
    expect_grant(0);
    finish_grant();
    req = 4'b0000;

    // 4: withdraw without ack releases and advances ptr; with ack goes BUSY
    req = 4'b0100;
    expect_grant(2);
    req = 4'b0000;
    tick();
    chk("withdraw_gnt", gnt, 0);
    chk("withdraw_busy", busy, 0);
    req = 4'b1111;
    expect_grant(3);
    finish_grant();
    req = 4'b0000;
    req = 4'b0100;
    expect_grant(2);
    req = 4'b0000;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_wins_busy", busy, 1);
    chk("ack_wins_gnt", gnt, 4'b0100);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("ack_wins_release", gnt, 0);

    // 5: asynchronous reset mid-BUSY
    req = 4'b0100;
    expect_grant(2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_idx", gnt_idx, 0);
    tick(2);
    rst_n = 1'b1;
    expect_grant(2);
    finish_grant();
    req = 4'b0000;

    // 6: busy timeout (or indefinite BUSY when the feature is out)
    req = 4'b0001;
    expect_grant(0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
`ifdef RR_DECODE_ARBITER_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("tmo_early", tmo_err, 0);
    end
    chk("tmo_busy_7", busy, 1);
    tick();
    chk("tmo_pulse", tmo_err, 1);
    chk("tmo_gnt", gnt, 0);
    chk("tmo_busy", busy, 0);
    req = 4'b0000;
    tick();
    chk("tmo_single", tmo_err, 0);
    req = 4'b0001;
    expect_grant(0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(7);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_wins_tmo", tmo_err, 0);
    chk("done_wins_busy", busy, 0);
    chk("done_wins_gnt", gnt, 0);
    req = 4'b0000;
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("no_tmo", tmo_err, 0);
    end
    chk("busy_held", busy, 1);
    chk("gnt_held", gnt, 4'b0001);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("late_done_gnt", gnt, 0);
    req = 4'b0000;
`endif

    tick(3);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
